// File: rtl/blink_rtc_n.sv
// Real-time clock and timer-interrupt unit: mck -> ticks -> seconds -> minutes,
// with sticky masked status, a seconds alarm and a coherent snapshot for multi-byte reads.
module blink_rtc_n #(
  parameter int TICK_DIV      = 49152,
  parameter int TICKS_PER_SEC = 200,
  parameter int MIN_W         = 21
) (
  input  logic       mck,
  input  logic       rin_n,
  input  logic       rst_tim,
  input  logic       reg_wr,
  input  logic       reg_rd,
  input  logic [2:0] reg_a,
  input  logic [7:0] reg_di,
  output logic [7:0] reg_do,
  output logic       irq
);

  localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DCNT_MAX = DW'(TICK_DIV - 1);
  localparam logic [7:0]    TIM0_MAX = 8'(TICKS_PER_SEC - 1);

  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [7:0]       tim0_q, tim0_d;
  logic [5:0]       tim1_q, tim1_d;
  logic [MIN_W-1:0] timm_q, timm_d;
  logic [3:0]       tsta_q, tsta_d;
  logic [3:0]       tmk_q, tmk_d;
  logic [7:0]       alm_q, alm_d;
  logic [5:0]       snap_tim1_q, snap_tim1_d;
  logic [MIN_W-1:0] snap_timm_q, snap_timm_d;
  logic [7:0]       reg_do_q, reg_do_d;

  logic       tick_ev, sec_ev, min_ev, alarm_ev;
  logic [7:0] rd_val;
  logic [23:0] snap_ext;

  // The whole cascade settles in one cycle so tick, sec and min can fire on the same edge.
  always_comb begin
    dcnt_d   = dcnt_q + 1'b1;
    tim0_d   = tim0_q;
    tim1_d   = tim1_q;
    timm_d   = timm_q;
    tick_ev  = 1'b0;
    sec_ev   = 1'b0;
    min_ev   = 1'b0;
    alarm_ev = 1'b0;
    if (rst_tim) begin
      dcnt_d = '0;
      tim0_d = '0;
      tim1_d = '0;
      timm_d = '0;
    end else if (dcnt_q == DCNT_MAX) begin
      dcnt_d  = '0;
      tick_ev = 1'b1;
      if (tim0_q == TIM0_MAX) begin
        tim0_d = '0;
        sec_ev = 1'b1;
        if (tim1_q == 6'd59) begin
          tim1_d = '0;
          min_ev = 1'b1;
          timm_d = timm_q + 1'b1;
        end else begin
          tim1_d = tim1_q + 1'b1;
        end
        // tim1 never exceeds 59, so alarm seconds of 60..63 can never match
        alarm_ev = alm_q[7] && (tim1_d == alm_q[5:0]);
      end else begin
        tim0_d = tim0_q + 1'b1;
      end
    end
  end

  always_comb begin
    tsta_d = tsta_q;
    if (reg_wr && reg_a == 3'd5) tsta_d = tsta_q & ~reg_di[3:0];
    tsta_d = tsta_d | {alarm_ev, min_ev, sec_ev, tick_ev};
    tmk_d  = (reg_wr && reg_a == 3'd6) ? reg_di[3:0] : tmk_q;
    alm_d  = (reg_wr && reg_a == 3'd7) ? {reg_di[7], 1'b0, reg_di[5:0]} : alm_q;
  end

  assign snap_ext = 24'(snap_timm_q);

  // Reads use pre-edge state, so a tim0 read and its snapshot describe the same instant.
  always_comb begin
    rd_val = 8'h00;
    case (reg_a)
      3'd0:    rd_val = tim0_q;
      3'd1:    rd_val = {2'b00, snap_tim1_q};
      3'd2:    rd_val = snap_ext[7:0];
      3'd3:    rd_val = snap_ext[15:8];
      3'd4:    rd_val = snap_ext[23:16];
      3'd5:    rd_val = {4'h0, tsta_q};
      3'd6:    rd_val = {4'h0, tmk_q};
      default: rd_val = alm_q;
    endcase
    reg_do_d    = reg_rd ? rd_val : reg_do_q;
    snap_tim1_d = snap_tim1_q;
    snap_timm_d = snap_timm_q;
    if (reg_rd && reg_a == 3'd0) begin
      snap_tim1_d = tim1_q;
      snap_timm_d = timm_q;
    end
  end

  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      dcnt_q      <= '0;
      tim0_q      <= '0;
      tim1_q      <= '0;
      timm_q      <= '0;
      tsta_q      <= '0;
      tmk_q       <= '0;
      alm_q       <= '0;
      snap_tim1_q <= '0;
      snap_timm_q <= '0;
      reg_do_q    <= '0;
    end else begin
      dcnt_q      <= dcnt_d;
      tim0_q      <= tim0_d;
      tim1_q      <= tim1_d;
      timm_q      <= timm_d;
      tsta_q      <= tsta_d;
      tmk_q       <= tmk_d;
      alm_q       <= alm_d;
      snap_tim1_q <= snap_tim1_d;
      snap_timm_q <= snap_timm_d;
      reg_do_q    <= reg_do_d;
    end
  end

  assign reg_do = reg_do_q;
  assign irq    = |(tsta_q & tmk_q);

endmodule

// File: tb/tb_blink_rtc_n.sv
// Self-checking bench for blink_rtc_n: directed scenarios plus random register traffic,
// compared every cycle against an elapsed-cycle arithmetic model of the clock.
module tb_blink_rtc_n;

  localparam int TD   = 4;
  localparam int TPS  = 3;
  localparam int SECC = TD * TPS;
  localparam int MINC = SECC * 60;
  localparam int MMOD = 131072;

  logic       mck = 1'b0;
  logic       rin_n = 1'b0;
  logic       rst_tim = 1'b0;
  logic       reg_wr = 1'b0;
  logic       reg_rd = 1'b0;
  logic [2:0] reg_a = 3'd0;
  logic [7:0] reg_di = 8'h00;
  logic [7:0] reg_do;
  logic       irq;

  int totalChecks = 0;
  int badChecks = 0;

  // Model: the clock is just the count of cycles since counting (re)started.
  int         modelN = 0;
  logic [3:0] mTsta = 4'h0;
  logic [3:0] mTmk = 4'h0;
  logic [7:0] mAlm = 8'h00;
  logic [7:0] mDo = 8'h00;
  logic [5:0] mSnap1 = 6'd0;
  logic [16:0] mSnapM = 17'd0;

  blink_rtc_n #(.TICK_DIV(TD), .TICKS_PER_SEC(TPS), .MIN_W(17)) dut (
    .mck(mck), .rin_n(rin_n), .rst_tim(rst_tim), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_a(reg_a), .reg_di(reg_di), .reg_do(reg_do), .irq(irq)
  );

  always #5 mck = ~mck;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic resetModel();
    modelN = 0; mTsta = 4'h0; mTmk = 4'h0; mAlm = 8'h00;
    mDo = 8'h00; mSnap1 = 6'd0; mSnapM = 17'd0;
  endtask

  // Advances the model by one clock edge given the inputs presented on that edge.
  task automatic stepModel(input logic rt, input logic wr, input logic rd,
                           input logic [2:0] a, input logic [7:0] di);
    logic [7:0] rv;
    logic [3:0] ev;
    case (a)
      3'd0: rv = 8'((modelN / TD) % TPS);
      3'd1: rv = {2'b00, mSnap1};
      3'd2: rv = mSnapM[7:0];
      3'd3: rv = mSnapM[15:8];
      3'd4: rv = {7'd0, mSnapM[16]};
      3'd5: rv = {4'h0, mTsta};
      3'd6: rv = {4'h0, mTmk};
      default: rv = mAlm;
    endcase
    if (rd) begin
      mDo = rv;
      if (a == 3'd0) begin
        mSnap1 = 6'((modelN / SECC) % 60);
        mSnapM = 17'((modelN / MINC) % MMOD);
      end
    end
    ev = 4'h0;
    if (rt) modelN = 0;
    else begin
      modelN++;
      if (modelN % TD == 0) ev[0] = 1'b1;
      if (modelN % SECC == 0) ev[1] = 1'b1;
      if (modelN % MINC == 0) ev[2] = 1'b1;
      if (ev[1] && mAlm[7] && ((modelN / SECC) % 60 == int'(mAlm[5:0]))) ev[3] = 1'b1;
    end
    if (wr && a == 3'd5) mTsta = mTsta & ~di[3:0];
    mTsta = mTsta | ev;
    if (wr && a == 3'd6) mTmk = di[3:0];
    if (wr && a == 3'd7) mAlm = {di[7], 1'b0, di[5:0]};
  endtask

  // One full clock: drive at negedge, step model on posedge, compare 1ns later.
  task automatic applyStimulus(input logic rt, input logic wr, input logic rd,
                               input logic [2:0] a, input logic [7:0] di);
    rst_tim = rt; reg_wr = wr; reg_rd = rd; reg_a = a; reg_di = di;
    @(posedge mck);
    stepModel(rt, wr, rd, a, di);
    #1;
    checkOutput("irq", {31'd0, irq}, {31'd0, |(mTsta & mTmk)});
    checkOutput("reg_do", {24'd0, reg_do}, {24'd0, mDo});
    @(negedge mck);
    rst_tim = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  // Main sequence: directed scenarios first, then random traffic, then async reset.
  initial begin
    #12;
    checkOutput("resetIrq", {31'd0, irq}, 32'd0);
    checkOutput("resetDo", {24'd0, reg_do}, 32'd0);
    @(negedge mck);
    rin_n = 1'b1;
    resetModel();

    // Tick interrupt, then acknowledge it.
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd6, 8'h01);
    idle(6);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd5, 8'h01);
    idle(1);

    // Run past the first minute and read back the snapshot.
    idle(MINC);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 8'h00);
    checkOutput("timmLowAfterMinute", {24'd0, reg_do}, 32'h01);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd5, 8'h00);

    // Alarm on second 5, then an unreachable alarm second of 60.
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd7, 8'h85);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd6, 8'h08);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd5, 8'h0F);
    idle(2 * MINC);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd7, 8'hBC);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd5, 8'h0F);
    idle(2 * MINC);
    checkOutput("alm60NoFire", {31'd0, irq}, 32'd0);

    // Acknowledge on the same edge as a tick: the tick must survive.
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd6, 8'h01);
    for (int i = 0; i < TD && (modelN % TD) != TD - 1; i++) idle(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd5, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd5, 8'h00);
    checkOutput("ackTickSetWins", {31'd0, reg_do[0]}, 32'd1);

    // Hold the counters in clear for 10 cycles mid-count.
    idle(7);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 8'h0F);
    checkOutput("tim0AfterClear", {24'd0, reg_do}, 32'd0);
    idle(5);

    // Random register traffic with occasional counter clears.
    for (int i = 0; i < 4000; i++) begin
      logic rt, wr, rd;
      logic [2:0] a;
      logic [7:0] di;
      rt = ($urandom_range(0, 199) == 0);
      wr = ($urandom_range(0, 99) < 6);
      rd = ($urandom_range(0, 99) < 35);
      a  = 3'($urandom_range(0, 7));
      di = 8'($urandom);
      if (wr && a == 3'd7 && $urandom_range(0, 1) == 1) di = {1'b1, 1'b0, 6'($urandom_range(0, 63))};
      applyStimulus(rt, wr, rd, a, di);
    end

    // Asynchronous reset between clock edges clears outputs at once.
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd7, 8'h9F);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd6, 8'h0F);
    idle(5);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd7, 8'h00);
    #2;
    rin_n = 1'b0;
    #1;
    checkOutput("asyncResetIrq", {31'd0, irq}, 32'd0);
    checkOutput("asyncResetDo", {24'd0, reg_do}, 32'd0);
    @(negedge mck);
    rin_n = 1'b1;
    resetModel();
    idle(10);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
